// File: rtl/division_arbiter.sv
// division_arbiter: round-robin front end for one restoring shift-subtract divider
// shared by two requesters; results return on a shared registered bus with a Done pulse.
module division_arbiter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Req0,
   input  logic             Req1,
   input  logic [WIDTH-1:0] Dividend0,
   input  logic [WIDTH-1:0] Divisor0,
   input  logic [WIDTH-1:0] Dividend1,
   input  logic [WIDTH-1:0] Divisor1,
   output logic             Ack0,
   output logic             Ack1,
   output logic             Done0,
   output logic             Done1,
   output logic [WIDTH-1:0] Quotient,
   output logic [WIDTH-1:0] Remainder,
   output logic             DivZero,
   output logic             Busy
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, CALC, ZERO} state_t;
   state_t state;
   logic [CW-1:0] cnt;
   logic last_grant, grant, pick1, qbit;
   logic [WIDTH-1:0] dvd, dvs, rem, next_rem, sel_dvd, sel_dvs;
   logic [WIDTH:0] shifted, diff;
   always_comb begin
      pick1 = Req1 & (~Req0 | ~last_grant);
      sel_dvd = pick1 ? Dividend1 : Dividend0;
      sel_dvs = pick1 ? Divisor1 : Divisor0;
      shifted = {rem, dvd[WIDTH-1]};
      diff = shifted - {1'b0, dvs};
      qbit = ~diff[WIDTH];
      next_rem = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
   end
   assign Busy = state != IDLE;
   // dvd doubles as the quotient shift register: dividend bits leave at the top
   // while quotient bits enter at the bottom
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         last_grant <= 1'b1;
         grant <= 1'b0;
         dvd <= '0;
         dvs <= '0;
         rem <= '0;
         Ack0 <= 1'b0;
         Ack1 <= 1'b0;
         Done0 <= 1'b0;
         Done1 <= 1'b0;
         DivZero <= 1'b0;
         Quotient <= '0;
         Remainder <= '0;
      end else begin
         Ack0 <= 1'b0;
         Ack1 <= 1'b0;
         Done0 <= 1'b0;
         Done1 <= 1'b0;
         DivZero <= 1'b0;
         case (state)
            IDLE: if (Req0 | Req1) begin
               grant <= pick1;
               last_grant <= pick1;
               Ack0 <= ~pick1;
               Ack1 <= pick1;
               dvd <= sel_dvd;
               dvs <= sel_dvs;
               rem <= '0;
               cnt <= '0;
               state <= sel_dvs == '0 ? ZERO : CALC;
            end
            CALC: begin
               rem <= next_rem;
               dvd <= {dvd[WIDTH-2:0], qbit};
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  Quotient <= {dvd[WIDTH-2:0], qbit};
                  Remainder <= next_rem;
                  Done0 <= ~grant;
                  Done1 <= grant;
                  state <= IDLE;
               end
            end
            ZERO: begin
               Quotient <= '1;
               Remainder <= dvd;
               DivZero <= 1'b1;
               Done0 <= ~grant;
               Done1 <= grant;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
